// File: rtl/gate_response_checker.sv
// Checks observed buf/nand/xnor responses (2-bit 0/1/x/z codes) against the expected
// values for each accepted input pair; tracks pass/fail counts, input coverage and the first failure.
module gate_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       x_code,
  input  logic [1:0]       y_code,
  input  logic [1:0]       buf_code,
  input  logic [1:0]       nand_code,
  input  logic [1:0]       xnor_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [15:0]      coverage,
  output logic             fail_seen,
  output logic [3:0]       first_fail_idx,
  output logic [2:0]       first_fail_gate,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0] C_ZERO = 2'b00;
  localparam logic [1:0] C_ONE  = 2'b01;
  localparam logic [1:0] C_X    = 2'b10;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic [15:0]      r_cov;
  logic             r_seen;
  logic [3:0]       r_idx;
  logic [2:0]       r_gate;

  logic             w_xfer;
  logic             w_start_acc;
  logic [3:0]       w_idx;
  logic [15:0]      w_cov_next;
  logic             w_x_known;
  logic             w_y_known;
  logic [1:0]       w_exp_buf;
  logic [1:0]       w_exp_nand;
  logic [1:0]       w_exp_xnor;
  logic [2:0]       w_mask;

  // Handshake: a sample transfers on a rising edge when in_valid && in_ready;
  // in_ready depends only on the state (high exactly in RUN), never on in_valid.
  assign in_ready    = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign dbg_state   = r_state;
  assign w_xfer      = in_valid && in_ready;
  assign w_start_acc = start && (r_state != S_RUN);
  assign w_idx       = {x_code, y_code};
  assign w_cov_next  = r_cov | (16'h0001 << w_idx);

  // A code with bit 1 set is x or z; both are treated as unknown.
  assign w_x_known = ~x_code[1];
  assign w_y_known = ~y_code[1];

  always_comb begin
    w_exp_buf  = C_X;
    w_exp_nand = C_X;
    w_exp_xnor = C_X;
    if (w_x_known) w_exp_buf = x_code;
    if (x_code == C_ZERO || y_code == C_ZERO) w_exp_nand = C_ONE;
    else if (x_code == C_ONE && y_code == C_ONE) w_exp_nand = C_ZERO;
    if (w_x_known && w_y_known) w_exp_xnor = {1'b0, ~(x_code[0] ^ y_code[0])};
  end

  assign w_mask = {buf_code != w_exp_buf, nand_code != w_exp_nand, xnor_code != w_exp_xnor};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_xfer && (w_cov_next == 16'hFFFF)) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= '0;
      r_fail <= '0;
      r_cov  <= '0;
      r_seen <= 1'b0;
      r_idx  <= '0;
      r_gate <= '0;
    end else if (w_start_acc) begin
      r_pass <= '0;
      r_fail <= '0;
      r_cov  <= '0;
      r_seen <= 1'b0;
      r_idx  <= '0;
      r_gate <= '0;
    end else if (w_xfer) begin
      r_cov <= w_cov_next;
      if (w_mask == 3'b000) begin
        if (r_pass != {CNT_W{1'b1}}) r_pass <= r_pass + 1'b1;
      end else begin
        if (r_fail != {CNT_W{1'b1}}) r_fail <= r_fail + 1'b1;
        // Only the first mismatch of a run is recorded.
        if (!r_seen) begin
          r_seen <= 1'b1;
          r_idx  <= w_idx;
          r_gate <= w_mask;
        end
      end
    end
  end

  assign pass_cnt        = r_pass;
  assign fail_cnt        = r_fail;
  assign coverage        = r_cov;
  assign fail_seen       = r_seen;
  assign first_fail_idx  = r_idx;
  assign first_fail_gate = r_gate;

endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized and directed bench for gate_response_checker against a behavioural model
// that derives expected gate outputs by enumerating every resolution of unknown inputs.
module tb_gate_response_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [1:0] x_code, y_code, buf_code, nand_code, xnor_code;

  logic       in_ready, busy, done, fail_seen;
  logic [7:0] pass_cnt, fail_cnt;
  logic [15:0] coverage;
  logic [3:0] first_fail_idx;
  logic [2:0] first_fail_gate;
  logic [1:0] dbg_state;

  logic       in_ready2, busy2, done2, fail_seen2;
  logic [1:0] pass_cnt2, fail_cnt2;
  logic [15:0] coverage2;
  logic [3:0] first_fail_idx2;
  logic [2:0] first_fail_gate2;
  logic [1:0] dbg_state2;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int          mdl_pass, mdl_fail;
  logic [15:0] mdl_cov;
  bit          mdl_run, mdl_done;
  logic [6:0]  exp_q[$];  // {idx, gate} of every mismatch in the current run

  gate_response_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x_code(x_code), .y_code(y_code), .buf_code(buf_code), .nand_code(nand_code),
    .xnor_code(xnor_code), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .coverage(coverage),
    .fail_seen(fail_seen), .first_fail_idx(first_fail_idx), .first_fail_gate(first_fail_gate),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  gate_response_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .x_code(x_code), .y_code(y_code), .buf_code(buf_code), .nand_code(nand_code),
    .xnor_code(xnor_code), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .coverage(coverage2),
    .fail_seen(fail_seen2), .first_fail_idx(first_fail_idx2), .first_fail_gate(first_fail_gate2),
    .busy(busy2), .done(done2), .dbg_state(dbg_state2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Gate output for all consistent 0/1 assignments of the inputs; a code with bit 1 set
  // (x or z) may be either value. Result is known only if every assignment agrees.
  function automatic logic [1:0] ref_gate(input int g, input logic [1:0] xc, input logic [1:0] yc);
    bit seen0 = 0, seen1 = 0;
    bit out;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        if (!xc[1] && a != int'(xc[0])) continue;
        if (!yc[1] && b != int'(yc[0])) continue;
        case (g)
          0:       out = (a == 1);
          1:       out = !(a == 1 && b == 1);
          default: out = (a == b);
        endcase
        if (out) seen1 = 1; else seen0 = 1;
      end
    end
    if (seen0 && seen1) return 2'b10;
    return seen1 ? 2'b01 : 2'b00;
  endfunction

  task automatic mdl_reset();
    mdl_pass = 0; mdl_fail = 0; mdl_cov = '0;
    mdl_run = 0; mdl_done = 0;
    exp_q.delete();
  endtask

  task automatic mdl_edge();
    logic [2:0] mask;
    if (!mdl_run) begin
      if (start) begin
        mdl_pass = 0; mdl_fail = 0; mdl_cov = '0;
        exp_q.delete();
        mdl_run = 1; mdl_done = 0;
      end
    end else if (in_valid) begin
      mask = {buf_code  != ref_gate(0, x_code, y_code),
              nand_code != ref_gate(1, x_code, y_code),
              xnor_code != ref_gate(2, x_code, y_code)};
      if (mask == 3'b000) mdl_pass = (mdl_pass < 255) ? mdl_pass + 1 : 255;
      else begin
        mdl_fail = (mdl_fail < 255) ? mdl_fail + 1 : 255;
        exp_q.push_back({x_code, y_code, mask});
      end
      mdl_cov[{x_code, y_code}] = 1'b1;
      if (mdl_cov == 16'hFFFF) begin
        mdl_run = 0; mdl_done = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [6:0] first;
    first = (exp_q.size() > 0) ? exp_q[0] : 7'd0;
    check("in_ready", in_ready, mdl_run);
    check("busy", busy, mdl_run);
    check("done", done, mdl_done);
    check("pass_cnt", pass_cnt, mdl_pass);
    check("fail_cnt", fail_cnt, mdl_fail);
    check("coverage", coverage, mdl_cov);
    check("fail_seen", fail_seen, exp_q.size() > 0);
    check("first_fail_idx", first_fail_idx, first[6:3]);
    check("first_fail_gate", first_fail_gate, first[2:0]);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge; the model steps at the rising edge and
  // outputs are compared at the following falling edge.
  task automatic step(input bit st, input bit v, input logic [1:0] xc, input logic [1:0] yc,
                      input logic [1:0] bc, input logic [1:0] nc, input logic [1:0] xn);
    start = st; in_valid = v;
    x_code = xc; y_code = yc; buf_code = bc; nand_code = nc; xnor_code = xn;
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
    start = 0; in_valid = 0;
    compare_all();
  endtask

  task automatic send_ok(input logic [1:0] xc, input logic [1:0] yc);
    step(0, 1, xc, yc, ref_gate(0, xc, yc), ref_gate(1, xc, yc), ref_gate(2, xc, yc));
  endtask

  task automatic do_start();
    step(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    mdl_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass_cnt, 0);
    check({tag, "_fail"}, fail_cnt, 0);
    check({tag, "_cov"}, coverage, 0);
    check({tag, "_seen"}, fail_seen, 0);
    check({tag, "_idx"}, first_fail_idx, 0);
    check({tag, "_gate"}, first_fail_gate, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ord[16];
    int tmp, j;
    logic [3:0] c;
    rst_n = 0; start = 0; in_valid = 0;
    x_code = 0; y_code = 0; buf_code = 0; nand_code = 0; xnor_code = 0;
    mdl_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // in_valid while IDLE has no effect
    repeat (3) send_ok(2'b01, 2'b01);
    check("idle_pass", pass_cnt, 0);
    check("idle_ready", in_ready, 0);

    // all 16 combinations, correct responses, shuffled order
    do_start();
    for (int i = 0; i < 16; i++) ord[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      c = ord[i][3:0];
      send_ok(c[3:2], c[1:0]);
    end
    check("full_pass", pass_cnt, 16);
    check("full_fail", fail_cnt, 0);
    check("full_cov", coverage, 16'hFFFF);
    check("full_done", done, 1);

    // in_valid while DONE has no effect
    repeat (3) send_ok(2'b00, 2'b01);
    check("done_pass", pass_cnt, 16);
    check("done_ready", in_ready, 0);

    // restart clears everything
    do_start();
    check("restart_pass", pass_cnt, 0);
    check("restart_cov", coverage, 0);
    check("restart_busy", busy, 1);

    // x=0, y=z, nand observed x instead of 1
    step(0, 1, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10);
    check("f1_fail", fail_cnt, 1);
    check("f1_seen", fail_seen, 1);
    check("f1_idx", first_fail_idx, 4'b0011);
    check("f1_gate", first_fail_gate, 3'b010);

    // a second, different failure leaves the first capture in place
    step(0, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
    check("f2_fail", fail_cnt, 2);
    check("f2_idx", first_fail_idx, 4'b0011);
    check("f2_gate", first_fail_gate, 3'b010);

    // reset mid-run after 7 transfers
    do_reset();
    do_start();
    for (int i = 0; i < 7; i++) send_ok($urandom_range(3, 0), $urandom_range(3, 0));
    #2 rst_n = 0;
    #1;
    mdl_reset();
    check_zero("midreset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    compare_all();
    do_start();
    check("after_reset_pass", pass_cnt, 0);

    // saturation of a 2-bit counter
    repeat (5) send_ok(2'b00, 2'b00);
    check("sat_pass2", pass_cnt2, 3);
    check("sat_done2", done2, 0);
    check("sat_pass8", pass_cnt, 5);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [1:0] xc, yc;
      bit st, v;
      st = ($urandom_range(19, 0) == 0);
      v  = ($urandom_range(1, 0) == 1);
      xc = $urandom_range(3, 0);
      yc = $urandom_range(3, 0);
      if ($urandom_range(9, 0) < 7)
        step(st, v, xc, yc, ref_gate(0, xc, yc), ref_gate(1, xc, yc), ref_gate(2, xc, yc));
      else
        step(st, v, xc, yc, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
